// File: rtl/wrr_bank_write_arbiter.sv
// Banked write arbiter: per-bank weighted round-robin over NUM_PORTS write requesters.
// Optional per-port grant / per-bank conflict counters under `WRR_BANK_ARB_STATS_EN.

module wrr_bank_arb #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  localparam int PORT_W   = $clog2(NUM_PORTS)
) (
  input  logic                               gclk,
  input  logic                               grst_n,
  input  logic [NUM_PORTS-1:0]               cand,
  input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0] weight,
  output logic [NUM_PORTS-1:0]               gnt,
  output logic [PORT_W-1:0]                  gnt_idx,
  output logic                               gnt_vld
);
  logic [PORT_W-1:0]   owner_q, owner_d, srch_idx;
  logic [WEIGHT_W-1:0] credit_q, credit_d, w_sel, eff_w;
  logic                hold, srch_vld;

  // Descending scan so the closest port after the owner wins; owner itself is last.
  always_comb begin
    srch_vld = 1'b0;
    srch_idx = owner_q;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (cand[PORT_W'((int'(owner_q) + i) % NUM_PORTS)]) begin
        srch_vld = 1'b1;
        srch_idx = PORT_W'((int'(owner_q) + i) % NUM_PORTS);
      end
    end
  end

  assign hold  = cand[owner_q] && (credit_q != '0);
  assign w_sel = weight[srch_idx];
  assign eff_w = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;

  always_comb begin
    owner_d  = owner_q;
    credit_d = '0;
    gnt_idx  = owner_q;
    gnt_vld  = 1'b0;
    if (hold) begin
      gnt_vld  = 1'b1;
      credit_d = credit_q - WEIGHT_W'(1);
    end else if (srch_vld) begin
      gnt_vld  = 1'b1;
      gnt_idx  = srch_idx;
      owner_d  = srch_idx;
      credit_d = eff_w - WEIGHT_W'(1);
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      owner_q  <= PORT_W'(NUM_PORTS - 1);
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end
endmodule

module wrr_bank_write_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 512,
  parameter int WEIGHT_W   = 4,
  localparam int BANK_LG   = $clog2(NUM_BANKS),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int BANK_AW   = ADDR_W - BANK_LG,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                                 switch_clk,
  input  logic                                 switch_rst_n,
  input  logic [NUM_PORTS-1:0]                 mem_we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     mem_waddr_i,
  input  logic [NUM_PORTS-1:0][BLOCK_BITS-1:0] mem_wdata_i,
  input  logic [NUM_PORTS-1:0][WEIGHT_W-1:0]   weight_i,
  output logic [NUM_PORTS-1:0]                 mem_gnt_o,
  output logic [NUM_BANKS-1:0]                 bank_we_o,
  output logic [NUM_BANKS-1:0][BANK_AW-1:0]    bank_waddr_o,
  output logic [NUM_BANKS-1:0][BLOCK_BITS-1:0] bank_wdata_o
`ifdef WRR_BANK_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]           grant_cnt_o,
  output logic [NUM_BANKS-1:0][15:0]           conflict_cnt_o
`endif
);
  logic [NUM_PORTS-1:0][BANK_W-1:0]    port_bank;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] cand, bank_gnt;
  logic [NUM_BANKS-1:0][PORT_W-1:0]    bank_gidx;
  logic [NUM_BANKS-1:0]                bank_gvld;
  logic [NUM_PORTS-1:0]                gnt_any;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    if (NUM_BANKS > 1) begin : g_multi
      assign port_bank[p] = mem_waddr_i[p][BANK_LG-1:0];
    end else begin : g_single
      assign port_bank[p] = '0;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      for (int p = 0; p < NUM_PORTS; p++)
        cand[b][p] = mem_we_i[p] && (port_bank[p] == BANK_W'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    wrr_bank_arb #(.NUM_PORTS(NUM_PORTS), .WEIGHT_W(WEIGHT_W)) u_arb (
      .gclk    (switch_clk),
      .grst_n  (switch_rst_n),
      .cand    (cand[b]),
      .weight  (weight_i),
      .gnt     (bank_gnt[b]),
      .gnt_idx (bank_gidx[b]),
      .gnt_vld (bank_gvld[b])
    );

    // Address/data only move on a write so the bank sees stable values when idle.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
        bank_we_o[b]    <= 1'b0;
        bank_waddr_o[b] <= '0;
        bank_wdata_o[b] <= '0;
      end else begin
        bank_we_o[b] <= bank_gvld[b];
        if (bank_gvld[b]) begin
          bank_waddr_o[b] <= mem_waddr_i[bank_gidx[b]][ADDR_W-1:BANK_LG];
          bank_wdata_o[b] <= mem_wdata_i[bank_gidx[b]];
        end
      end
    end
  end

  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_any |= bank_gnt[b];
  end

  // Suppress grants during reset: the requester must not believe a lost write landed.
  assign mem_gnt_o = gnt_any & {NUM_PORTS{switch_rst_n}};

`ifdef WRR_BANK_ARB_STATS_EN
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      grant_cnt_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt_any[p] && grant_cnt_o[p] != 16'hFFFF) grant_cnt_o[p] <= grant_cnt_o[p] + 16'd1;
      for (int b = 0; b < NUM_BANKS; b++)
        if (($countones(cand[b]) >= 2) && conflict_cnt_o[b] != 16'hFFFF)
          conflict_cnt_o[b] <= conflict_cnt_o[b] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wrr_bank_write_arbiter.sv
// Scoreboard bench for wrr_bank_write_arbiter (4 ports, 2 banks): model grants, queued bank writes.
module tb_wrr_bank_write_arbiter;
  localparam int NP = 4, NB = 2, AW = 10, BB = 512, WW = 4, BAW = 9;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NP-1:0]          mem_we_i;
  logic [NP-1:0][AW-1:0]  mem_waddr_i;
  logic [NP-1:0][BB-1:0]  mem_wdata_i;
  logic [NP-1:0][WW-1:0]  weight_i;
  logic [NP-1:0]          mem_gnt_o;
  logic [NB-1:0]          bank_we_o;
  logic [NB-1:0][BAW-1:0] bank_waddr_o;
  logic [NB-1:0][BB-1:0]  bank_wdata_o;
`ifdef WRR_BANK_ARB_STATS_EN
  logic [NP-1:0][15:0]    grant_cnt_o;
  logic [NB-1:0][15:0]    conflict_cnt_o;
`endif

  always #5 clk = ~clk;

  wrr_bank_write_arbiter dut (
    .switch_clk   (clk),
    .switch_rst_n (rst_n),
    .mem_we_i     (mem_we_i),
    .mem_waddr_i  (mem_waddr_i),
    .mem_wdata_i  (mem_wdata_i),
    .weight_i     (weight_i),
    .mem_gnt_o    (mem_gnt_o),
    .bank_we_o    (bank_we_o),
    .bank_waddr_o (bank_waddr_o),
    .bank_wdata_o (bank_wdata_o)
`ifdef WRR_BANK_ARB_STATS_EN
    ,
    .grant_cnt_o    (grant_cnt_o),
    .conflict_cnt_o (conflict_cnt_o)
`endif
  );

  typedef struct {
    int            bank;
    logic [BAW-1:0] addr;
    logic [BB-1:0]  data;
  } wr_t;

  wr_t            sb[$];
  logic [NP-1:0]  gnt_hist[$];
  int             m_owner[NB];
  int             m_credit[NB];
  logic [BAW-1:0] last_addr[NB];
  logic [BB-1:0]  last_data[NB];
  int             checks = 0;
  int             failures = 0;

  task automatic chk(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int effw(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  // One cycle: at the falling edge check last cycle's writes, then model this cycle's grants.
  task automatic tick();
    logic [NB-1:0] ew;
    logic [NP-1:0] eg;
    logic [NP-1:0] c;
    int            g;
    wr_t           e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_gnt", mem_gnt_o, '0);
      chk("rst_we", bank_we_o, '0);
      for (int b = 0; b < NB; b++) begin
        m_owner[b] = NP - 1; m_credit[b] = 0; last_addr[b] = '0; last_data[b] = '0;
      end
      sb.delete();
    end else begin
      ew = '0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        ew[e.bank] = 1'b1; last_addr[e.bank] = e.addr; last_data[e.bank] = e.data;
      end
      chk("bank_we", bank_we_o, ew);
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("bank_waddr%0d", b), bank_waddr_o[b], last_addr[b]);
        chk($sformatf("bank_wdata%0d", b), bank_wdata_o[b], last_data[b]);
      end
      eg = '0;
      for (int b = 0; b < NB; b++) begin
        for (int p = 0; p < NP; p++) c[p] = mem_we_i[p] && (int'(mem_waddr_i[p]) % NB == b);
        g = -1;
        if (c[m_owner[b]] && m_credit[b] != 0) begin
          g = m_owner[b];
          m_credit[b]--;
        end else begin
          for (int i = 1; i <= NP; i++) begin
            int q = (m_owner[b] + i) % NP;
            if (g < 0 && c[q]) g = q;
          end
          if (g >= 0) begin
            m_owner[b] = g;
            m_credit[b] = effw(int'(weight_i[g])) - 1;
          end else m_credit[b] = 0;
        end
        if (g >= 0) begin
          eg[g] = 1'b1;
          sb.push_back('{b, mem_waddr_i[g][AW-1:1], mem_wdata_i[g]});
        end
      end
      chk("mem_gnt", mem_gnt_o, eg);
      gnt_hist.push_back(mem_gnt_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [WW-1:0] w);
    logic [BB-1:0] d;
    for (int k = 0; k < BB / 32; k++) d[k*32 +: 32] = $urandom();
    mem_we_i[p] = we; mem_waddr_i[p] = a; weight_i[p] = w; mem_wdata_i[p] = d;
  endtask

  task automatic idle_all();
    mem_we_i = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Compare recorded grant vectors to an independent list of port indices (-1 = none).
  task automatic chk_seq(input string tag, input int e[$]);
    logic [NP-1:0] oh;
    chk({tag, "_len"}, BB'(gnt_hist.size()), BB'(e.size()));
    for (int i = 0; i < e.size() && i < gnt_hist.size(); i++) begin
      oh = '0;
      if (e[i] >= 0) oh[e[i]] = 1'b1;
      chk($sformatf("%s[%0d]", tag, i), gnt_hist[i], oh);
    end
  endtask

  initial begin
    int e[$];
    mem_we_i = '0; mem_waddr_i = '0; mem_wdata_i = '0; weight_i = '{default: 4'd1};
    #1;
    do_reset();

    // Idle after reset.
    gnt_hist.delete();
    repeat (10) tick();
    e.delete();
    for (int i = 0; i < 10; i++) e.push_back(-1);
    chk_seq("t1_idle", e);

    // Two ports, two banks, same cycle.
    set_port(0, 1'b1, 10'h002, 4'd1);
    set_port(1, 1'b1, 10'h003, 4'd1);
    gnt_hist.delete();
    tick();
    idle_all();
    tick();
    chk("t2_gnt", gnt_hist[0], 4'b0011);
    chk("t2_addr0", bank_waddr_o[0], 9'h001);
    chk("t2_addr1", bank_waddr_o[1], 9'h001);

    // Weighted sequence {3,1,2,1} on bank 0.
    do_reset();
    set_port(0, 1'b1, 10'h010, 4'd3);
    set_port(1, 1'b1, 10'h012, 4'd1);
    set_port(2, 1'b1, 10'h014, 4'd2);
    set_port(3, 1'b1, 10'h016, 4'd1);
    gnt_hist.delete();
    repeat (14) tick();
    e = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
    chk_seq("t3_wrr", e);
    idle_all();
    tick();

    // Request gap forfeits credit; re-request restarts with full weight.
    do_reset();
    set_port(2, 1'b1, 10'h020, 4'd4);
    gnt_hist.delete();
    tick();
    set_port(1, 1'b1, 10'h030, 4'd1);
    tick();
    mem_we_i[2] = 1'b0;
    tick();
    mem_we_i[1] = 1'b0;
    set_port(2, 1'b1, 10'h022, 4'd4);
    set_port(3, 1'b1, 10'h036, 4'd1);
    repeat (5) tick();
    e = '{2, 2, 1, 2, 2, 2, 2, 3};
    chk_seq("t4_gap", e);
    idle_all();
    tick();

    // Zero weight behaves as one.
    do_reset();
    set_port(0, 1'b1, 10'h040, 4'd1);
    set_port(1, 1'b1, 10'h042, 4'd0);
    gnt_hist.delete();
    repeat (6) tick();
    e = '{0, 1, 0, 1, 0, 1};
    chk_seq("t5_w0", e);
    idle_all();
    tick();

    // Asynchronous reset mid-burst.
    do_reset();
    set_port(0, 1'b1, 10'h050, 4'd3);
    set_port(1, 1'b1, 10'h052, 4'd1);
    tick();
    chk("t6_we_pre", bank_we_o, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", bank_we_o, 2'b00);
    chk("t6_gnt_rst", mem_gnt_o, 4'b0000);
`ifdef WRR_BANK_ARB_STATS_EN
    chk("t6_gcnt_rst", grant_cnt_o, '0);
    chk("t6_ccnt_rst", conflict_cnt_o, '0);
`endif
    tick();
    rst_n = 1'b1;
    mem_we_i[0] = 1'b0;
    set_port(2, 1'b1, 10'h054, 4'd1);
    gnt_hist.delete();
    tick();
    chk("t6_first", gnt_hist[0], 4'b0010);
    idle_all();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
